rcc_sys_clk_sw_ctrl: RTL and testbench
======================================

RCC_SYS_CLK_SW_CTRL -- requirements
Module: rcc_sys_clk_sw_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 4: cycles the sys_clk_sel value is held before status is updated, covering the glitch-free switch latency.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1024: maximum cycles spent waiting for the target oscillator to become ready.
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port sys_clk_sw, input, 2 bits: requested source (00 HSI, 01 CSI, 10 HSE, 11 PLL1).
REQ-006 The block SHALL have ports hsi_rdy, csi_rdy, hse_rdy and pll1_rdy, each input, 1 bit: oscillator and PLL ready flags.
REQ-007 The block SHALL have port pll1_src_hse, input, 1 bit: PLL1 reference is HSE.
REQ-008 The block SHALL have port hsecss_fail, input, 1 bit: HSE clock security failure, level.
REQ-009 The block SHALL have ports rcc_sys_stop, input, 1 bit (system stop mode active) and stopwuck, input, 1 bit (wake-up clock: 0 HSI, 1 CSI).
REQ-010 The block SHALL have port sys_clk_sel, output, 2 bits: select driven to the system clock switch.
REQ-011 The block SHALL have port sws, output, 2 bits: current source status.
REQ-012 The block SHALL have port sw_busy, output, 1 bit: a switch is in progress.
REQ-013 The block SHALL have port sw_timeout, output, 1 bit: one-cycle pulse when a switch is aborted.
REQ-014 The block SHALL have port css_fallback, output, 1 bit: sticky flag, HSE failure forced HSI.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, WAIT_RDY, SETTLE and FORCE.
REQ-016 In IDLE, when sys_clk_sw differs from sws, rcc_sys_stop=0 and css_fallback=0, the FSM SHALL latch the target and go to WAIT_RDY with the counter cleared.
REQ-017 In WAIT_RDY, when the target's ready flag is 1, the FSM SHALL drive sys_clk_sel=target and go to SETTLE on the next cycle.
REQ-018 In WAIT_RDY, if the counter reaches TIMEOUT_CYC-1 with the target still not ready, the FSM SHALL pulse sw_timeout, return to IDLE, and leave sws and sys_clk_sel unchanged.
REQ-019 In SETTLE, after SETTLE_CYC cycles the block SHALL set sws=sys_clk_sel and return to IDLE.
REQ-020 The minimum request-to-sws latency SHALL be SETTLE_CYC+2 cycles.
REQ-021 A change of sys_clk_sw during WAIT_RDY or SETTLE SHALL be ignored until IDLE and then re-evaluated; there is no queueing.
REQ-022 The block SHALL treat the current source as HSE-dependent when sws=10, or when sws=11 and pll1_src_hse=1.
REQ-023 When hsecss_fail=1 and the current source or latched target is HSE-dependent, the block SHALL enter FORCE from any state in the next cycle (priority over all other events), set sys_clk_sel=00, set css_fallback=1, and run SETTLE to update sws=00.
REQ-024 Once css_fallback=1, the block SHALL ignore requests for HSE-dependent targets; other targets proceed normally.
REQ-025 css_fallback SHALL be cleared only by reset.
REQ-026 When rcc_sys_stop rises, the block SHALL abort any switch in progress without a sw_timeout pulse and return to IDLE.
REQ-027 While rcc_sys_stop=1, sys_clk_sel SHALL be held.
REQ-028 On the cycle rcc_sys_stop falls, the block SHALL drive sys_clk_sel={1'b0,stopwuck} and go to SETTLE, and then update sws to that value.
REQ-029 If hsecss_fail and a stop exit occur in the same cycle, the stop-exit wake-up selection SHALL win, since HSI/CSI are not HSE-dependent, and css_fallback SHALL still be set.
REQ-030 sw_busy SHALL be 1 in WAIT_RDY, SETTLE and FORCE, and 0 in IDLE.
REQ-031 The counter SHALL be $clog2(TIMEOUT_CYC)+1 bits wide, shared by WAIT_RDY and SETTLE, cleared on every state entry, and SHALL never wrap.

Reset
REQ-032 On sys_rst=1 at a clock edge, the block SHALL go to IDLE with sys_clk_sel=00, sws=00, sw_busy=0, sw_timeout=0, css_fallback=0, and the counter and latched target at 0.
REQ-033 Reset asserted mid-switch SHALL abandon the switch; outputs SHALL take their reset values on the following edge.

Structure
REQ-034 A shared package rcc_pkg SHALL hold the source encodings (SRC_HSI=2'b00, SRC_CSI=2'b01, SRC_HSE=2'b10, SRC_PLL1=2'b11) and the FSM state enum.
REQ-035 The block SHALL contain no sub-module; readiness selection and HSE-dependence SHALL be local combinational logic.

Verification
REQ-036 The bench SHALL check: reset, then sys_clk_sw=11 with pll1_rdy=1 -> sys_clk_sel=11 after 2 cycles, sws=11 six cycles after the request, sw_busy high for exactly those cycles.
REQ-037 The bench SHALL check: sys_clk_sw=10 with hse_rdy held 0 -> a single sw_timeout pulse at cycle 1024, sws=00, sys_clk_sel=00.
REQ-038 The bench SHALL check: sws=11 with pll1_src_hse=1, then hsecss_fail=1 -> sys_clk_sel=00 next cycle, css_fallback=1, sws=00 after settle; a later sys_clk_sw=10 is ignored.
REQ-039 The bench SHALL check: switch to CSI in progress, rcc_sys_stop=1 -> return to IDLE with no timeout pulse; with stopwuck=1, release stop -> sys_clk_sel=01 and sws=01 after settle.
REQ-040 The bench SHALL check: sys_rst asserted during SETTLE -> all outputs at reset values after one edge, with no sws update.

Source files
------------

// File: rtl/rcc_pkg.sv
// Shared encodings for the system clock switch controller: source codes,
// FSM states and the HSE-dependence test.
package rcc_pkg;

   localparam logic [1:0] SRC_HSI  = 2'b00;
   localparam logic [1:0] SRC_CSI  = 2'b01;
   localparam logic [1:0] SRC_HSE  = 2'b10;
   localparam logic [1:0] SRC_PLL1 = 2'b11;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      WAIT_RDY = 2'b01,
      SETTLE   = 2'b10,
      FORCE    = 2'b11
   } state_t;

   // A source depends on HSE if it is HSE itself or PLL1 fed from HSE.
   function automatic logic hse_dep(input logic [1:0] src, input logic pll1_src_hse);
      return (src == SRC_HSE) || ((src == SRC_PLL1) && pll1_src_hse);
   endfunction

endpackage

// File: rtl/rcc_sys_clk_sw_ctrl_if.sv
// Request/status bundle between the RCC register side and the clock switch controller.
interface rcc_sys_clk_sw_ctrl_if;

   logic [1:0] sys_clk_sw;
   logic       hsi_rdy;
   logic       csi_rdy;
   logic       hse_rdy;
   logic       pll1_rdy;
   logic       pll1_src_hse;
   logic       hsecss_fail;
   logic       rcc_sys_stop;
   logic       stopwuck;
   logic [1:0] sys_clk_sel;
   logic [1:0] sws;
   logic       sw_busy;
   logic       sw_timeout;
   logic       css_fallback;

   modport master (
      output sys_clk_sw, hsi_rdy, csi_rdy, hse_rdy, pll1_rdy, pll1_src_hse,
             hsecss_fail, rcc_sys_stop, stopwuck,
      input  sys_clk_sel, sws, sw_busy, sw_timeout, css_fallback
   );

   modport slave (
      input  sys_clk_sw, hsi_rdy, csi_rdy, hse_rdy, pll1_rdy, pll1_src_hse,
             hsecss_fail, rcc_sys_stop, stopwuck,
      output sys_clk_sel, sws, sw_busy, sw_timeout, css_fallback
   );

endinterface

// File: rtl/rcc_sys_clk_sw_ctrl.sv
// System clock source switch sequencer: waits for the target oscillator, drives the
// glitch-free switch select, holds it for a settle window, then reports the new status.
module rcc_sys_clk_sw_ctrl
   import rcc_pkg::*;
#(
   parameter int SETTLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   rcc_sys_clk_sw_ctrl_if.slave bus
);

   localparam int CW = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [CW-1:0] CNT_MAX     = '1;
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYC - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    tgt_q, tgt_d;
   logic [1:0]    sel_q, sel_d;
   logic [1:0]    sws_q, sws_d;
   logic          css_q, css_d;
   logic          stop_q;
   logic          timeout;

   logic stop_rise, stop_fall, tgt_rdy, cur_dep, pend_dep, force_evt, req_ok;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tgt_q   <= SRC_HSI;
         sel_q   <= SRC_HSI;
         sws_q   <= SRC_HSI;
         css_q   <= 1'b0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tgt_q   <= tgt_d;
         sel_q   <= sel_d;
         sws_q   <= sws_d;
         css_q   <= css_d;
         stop_q  <= bus.rcc_sys_stop;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      tgt_d   = tgt_q;
      sel_d   = sel_q;
      sws_d   = sws_q;
      css_d   = css_q;
      timeout = 1'b0;

      stop_rise = bus.rcc_sys_stop & ~stop_q;
      stop_fall = ~bus.rcc_sys_stop & stop_q;

      case (tgt_q)
         SRC_HSI:  tgt_rdy = bus.hsi_rdy;
         SRC_CSI:  tgt_rdy = bus.csi_rdy;
         SRC_HSE:  tgt_rdy = bus.hse_rdy;
         default:  tgt_rdy = bus.pll1_rdy;
      endcase

      cur_dep  = hse_dep(sws_q, bus.pll1_src_hse);
      pend_dep = ((state_q == WAIT_RDY) && hse_dep(tgt_q, bus.pll1_src_hse)) ||
                 ((state_q == SETTLE)   && hse_dep(sel_q, bus.pll1_src_hse));
      // Once recovery is underway (FORCE, or settling onto HSI) a still-asserted
      // failure must not restart it, or sws would never reach HSI.
      force_evt = bus.hsecss_fail && (cur_dep || pend_dep) && !bus.rcc_sys_stop &&
                  (state_q != FORCE) && !((state_q == SETTLE) && (sel_q == SRC_HSI));
      req_ok = (bus.sys_clk_sw != sws_q) && !bus.rcc_sys_stop &&
               !(css_q && hse_dep(bus.sys_clk_sw, bus.pll1_src_hse));

      if (stop_fall) begin
         sel_d   = {1'b0, bus.stopwuck};
         tgt_d   = {1'b0, bus.stopwuck};
         state_d = SETTLE;
         cnt_d   = '0;
         if (bus.hsecss_fail && cur_dep) css_d = 1'b1;
      end else if (force_evt) begin
         sel_d   = SRC_HSI;
         tgt_d   = SRC_HSI;
         css_d   = 1'b1;
         state_d = FORCE;
         cnt_d   = '0;
      end else if (stop_rise) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_ok) begin
                  tgt_d   = bus.sys_clk_sw;
                  state_d = WAIT_RDY;
                  cnt_d   = '0;
               end
            end
            WAIT_RDY: begin
               if (tgt_rdy) begin
                  sel_d   = tgt_q;
                  state_d = SETTLE;
                  cnt_d   = '0;
               end else if (cnt_q == TO_LAST) begin
                  timeout = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  sws_d   = sel_q;
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            FORCE: begin
               state_d = SETTLE;
               cnt_d   = '0;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign bus.sys_clk_sel  = sel_q;
   assign bus.sws          = sws_q;
   assign bus.sw_busy      = (state_q != IDLE);
   assign bus.sw_timeout   = timeout;
   assign bus.css_fallback = css_q;

endmodule

// File: tb/tb_rcc_sys_clk_sw_ctrl.sv
// Directed bench for the system clock switch controller: normal switch, ready timeout,
// HSE CSS fallback, stop entry/exit and reset mid-switch.
module tb_rcc_sys_clk_sw_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   pulses;

   always #5 clk = ~clk;

   rcc_sys_clk_sw_ctrl_if bus ();

   rcc_sys_clk_sw_ctrl #(.SETTLE_CYC(4), .TIMEOUT_CYC(1024)) dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (bus)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.sys_clk_sw   = 2'b00;
      bus.hsi_rdy      = 1'b1;
      bus.csi_rdy      = 1'b0;
      bus.hse_rdy      = 1'b0;
      bus.pll1_rdy     = 1'b0;
      bus.pll1_src_hse = 1'b0;
      bus.hsecss_fail  = 1'b0;
      bus.rcc_sys_stop = 1'b0;
      bus.stopwuck     = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick(2);
      chk("rst_sel", bus.sys_clk_sel, 0);
      chk("rst_sws", bus.sws, 0);
      chk("rst_busy", bus.sw_busy, 0);
      chk("rst_to", bus.sw_timeout, 0);
      chk("rst_css", bus.css_fallback, 0);
      rst = 1'b0;

      // Switch to PLL1, ready immediately
      bus.sys_clk_sw = 2'b11;
      bus.pll1_rdy   = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk($sformatf("pll_sel_c%0d", i), bus.sys_clk_sel, (i >= 2) ? 3 : 0);
         chk($sformatf("pll_sws_c%0d", i), bus.sws, (i >= 6) ? 3 : 0);
         chk($sformatf("pll_busy_c%0d", i), bus.sw_busy, (i <= 5) ? 1 : 0);
      end

      // Switch to HSE that never becomes ready
      do_reset();
      bus.sys_clk_sw = 2'b10;
      pulses = 0;
      for (int i = 1; i <= 1030; i++) begin
         tick();
         if (bus.sw_timeout === 1'b1) pulses++;
         if (i == 1024) begin
            chk("to_at_1024", bus.sw_timeout, 1);
            bus.sys_clk_sw = 2'b00;
         end
      end
      chk("to_pulses", pulses, 1);
      chk("to_sws", bus.sws, 0);
      chk("to_sel", bus.sys_clk_sel, 0);
      chk("to_busy", bus.sw_busy, 0);

      // HSE clock security failure while running from PLL1 on HSE
      do_reset();
      bus.pll1_src_hse = 1'b1;
      bus.pll1_rdy     = 1'b1;
      bus.sys_clk_sw   = 2'b11;
      tick(6);
      chk("css_pre_sws", bus.sws, 3);
      bus.hsecss_fail = 1'b1;
      tick();
      chk("css_sel", bus.sys_clk_sel, 0);
      chk("css_flag", bus.css_fallback, 1);
      chk("css_busy", bus.sw_busy, 1);
      tick(4);
      chk("css_sws_hold", bus.sws, 3);
      tick();
      chk("css_sws", bus.sws, 0);
      chk("css_busy_end", bus.sw_busy, 0);
      bus.hsecss_fail = 1'b0;
      bus.hse_rdy     = 1'b1;
      bus.sys_clk_sw  = 2'b10;
      tick(10);
      chk("css_ign_sws", bus.sws, 0);
      chk("css_ign_sel", bus.sys_clk_sel, 0);
      chk("css_ign_busy", bus.sw_busy, 0);
      chk("css_sticky", bus.css_fallback, 1);
      bus.csi_rdy    = 1'b1;
      bus.sys_clk_sw = 2'b01;
      tick(6);
      chk("css_csi_sws", bus.sws, 1);
      chk("css_csi_flag", bus.css_fallback, 1);

      // Stop mode aborts a pending CSI switch; wake-up on CSI
      do_reset();
      chk("stop_css_clr", bus.css_fallback, 0);
      bus.sys_clk_sw = 2'b01;
      pulses = 0;
      tick(2);
      chk("stop_wait_busy", bus.sw_busy, 1);
      bus.rcc_sys_stop = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (bus.sw_timeout === 1'b1) pulses++;
      end
      chk("stop_busy", bus.sw_busy, 0);
      chk("stop_sel", bus.sys_clk_sel, 0);
      chk("stop_pulses", pulses, 0);
      bus.stopwuck     = 1'b1;
      bus.csi_rdy      = 1'b1;
      bus.rcc_sys_stop = 1'b0;
      tick();
      chk("wake_sel", bus.sys_clk_sel, 1);
      chk("wake_busy", bus.sw_busy, 1);
      chk("wake_sws_hold", bus.sws, 0);
      tick(3);
      chk("wake_sws_pre", bus.sws, 0);
      tick();
      chk("wake_sws", bus.sws, 1);
      chk("wake_busy_end", bus.sw_busy, 0);

      // Reset in the middle of SETTLE
      do_reset();
      bus.pll1_rdy   = 1'b1;
      bus.sys_clk_sw = 2'b11;
      tick(3);
      chk("mid_sel", bus.sys_clk_sel, 3);
      chk("mid_busy", bus.sw_busy, 1);
      rst            = 1'b1;
      bus.sys_clk_sw = 2'b00;
      tick();
      chk("mid_rst_sel", bus.sys_clk_sel, 0);
      chk("mid_rst_sws", bus.sws, 0);
      chk("mid_rst_busy", bus.sw_busy, 0);
      chk("mid_rst_to", bus.sw_timeout, 0);
      chk("mid_rst_css", bus.css_fallback, 0);
      rst = 1'b0;
      tick(6);
      chk("mid_after_sws", bus.sws, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
